// File: rtl/hpf_mc.sv
// ============================================================================
// Module      : hpf_mc
// Description : Time-multiplexed multi-channel first-order DC-blocking HPF with
//               per-channel priming/clear and a 2-stage forwarded pipeline.
//               Build option HPF_MC_SATURATE_EN: saturate y_out instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpf_mc #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4,
    parameter int SHIFT    = 5,
    parameter int FRAC     = 6,
    parameter int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [CHW-1:0]   in_ch,
    input  logic [WIDTH-1:0] x_in,
    input  logic             clear_ch,
    input  logic [CHW-1:0]   clear_idx,
    output logic             out_valid,
    output logic [CHW-1:0]   out_ch,
    output logic [WIDTH-1:0] y_out
);

    localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ACCW = WIDTH + FRAC + 2;
    localparam int SUMW = ACCW + 2;
    localparam logic [CHW:0] NCH = (CHW + 1)'(CHANNELS);

    logic             s1_valid_q, s1_valid_d;
    logic [CHW-1:0]   s1_ch_q, s1_ch_d;
    logic [WIDTH-1:0] s1_x_q, s1_x_d;

    logic             s2_valid_q, s2_valid_d;
    logic [CHW-1:0]   s2_ch_q, s2_ch_d;
    logic [WIDTH-1:0] s2_x_q, s2_x_d;
    logic [ACCW-1:0]  s2_acc_q, s2_acc_d;
    logic [WIDTH-1:0] s2_xprev_q, s2_xprev_d;
    logic             s2_primed_q, s2_primed_d;

    logic [ACCW-1:0]     acc_q [CHANNELS];
    logic [ACCW-1:0]     acc_d [CHANNELS];
    logic [WIDTH-1:0]    xprev_q [CHANNELS];
    logic [WIDTH-1:0]    xprev_d [CHANNELS];
    logic [CHANNELS-1:0] primed_q, primed_d;

    logic             out_valid_q, out_valid_d;
    logic [CHW-1:0]   out_ch_q, out_ch_d;
    logic [WIDTH-1:0] y_out_q, y_out_d;

    logic                   w_accept;
    logic                   w_clr_ok;
    logic [WIDTH:0]         w_d;
    logic [SUMW-1:0]        w_d_ext;
    logic [SUMW-1:0]        w_sum;
    logic signed [ACCW-1:0] w_acc_sh;
    logic [ACCW-1:0]        w_acc_sat;
    logic [ACCW-1:0]        w_acc_new;
    logic [WIDTH-1:0]       w_y;
`ifdef HPF_MC_SATURATE_EN
    logic [ACCW-FRAC-1:0]   w_yfull;
`endif

    assign w_accept = in_valid & en & ({1'b0, in_ch} < NCH);
    assign w_clr_ok = clear_ch & ({1'b0, clear_idx} < NCH);

    // Filter datapath for the sample held in S2
    always_comb begin
        w_d      = {s2_x_q[WIDTH-1], s2_x_q} - {s2_xprev_q[WIDTH-1], s2_xprev_q};
        w_d_ext  = {{(SUMW-WIDTH-1){w_d[WIDTH]}}, w_d} << FRAC;
        w_acc_sh = $signed(s2_acc_q) >>> SHIFT;
        w_sum    = {{2{s2_acc_q[ACCW-1]}}, s2_acc_q} + w_d_ext
                 - {{2{w_acc_sh[ACCW-1]}}, w_acc_sh};
        if (w_sum[SUMW-1:ACCW-1] == {(SUMW-ACCW+1){w_sum[SUMW-1]}}) begin
            w_acc_sat = w_sum[ACCW-1:0];
        end else begin
            w_acc_sat = w_sum[SUMW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        end
        // First sample of a channel only latches x; output and acc stay zero
        w_acc_new = s2_primed_q ? w_acc_sat : '0;
`ifdef HPF_MC_SATURATE_EN
        w_yfull = w_acc_new[ACCW-1:FRAC];
        if (w_yfull[ACCW-FRAC-1:WIDTH-1] == {(ACCW-FRAC-WIDTH+1){w_yfull[ACCW-FRAC-1]}}) begin
            w_y = w_yfull[WIDTH-1:0];
        end else begin
            w_y = w_yfull[ACCW-FRAC-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
        w_y = w_acc_new[FRAC+WIDTH-1:FRAC];
`endif
    end

    // S1 -> S2 state fetch: a clear this edge beats S2 forwarding, which beats the array
    always_comb begin
        s1_valid_d = w_accept;
        s1_ch_d    = w_accept ? in_ch : s1_ch_q;
        s1_x_d     = w_accept ? x_in : s1_x_q;
        s2_valid_d = s1_valid_q;
        s2_ch_d    = s1_ch_q;
        s2_x_d     = s1_x_q;
        if (w_clr_ok && (clear_idx == s1_ch_q)) begin
            s2_acc_d    = '0;
            s2_xprev_d  = '0;
            s2_primed_d = 1'b0;
        end else if (s2_valid_q && (s2_ch_q == s1_ch_q)) begin
            s2_acc_d    = w_acc_new;
            s2_xprev_d  = s2_x_q;
            s2_primed_d = 1'b1;
        end else begin
            s2_acc_d    = acc_q[s1_ch_q[IDXW-1:0]];
            s2_xprev_d  = xprev_q[s1_ch_q[IDXW-1:0]];
            s2_primed_d = primed_q[s1_ch_q[IDXW-1:0]];
        end
    end

    always_comb begin
        acc_d    = acc_q;
        xprev_d  = xprev_q;
        primed_d = primed_q;
        if (s2_valid_q) begin
            acc_d[s2_ch_q[IDXW-1:0]]    = w_acc_new;
            xprev_d[s2_ch_q[IDXW-1:0]]  = s2_x_q;
            primed_d[s2_ch_q[IDXW-1:0]] = 1'b1;
        end
        if (w_clr_ok) begin
            acc_d[clear_idx[IDXW-1:0]]    = '0;
            xprev_d[clear_idx[IDXW-1:0]]  = '0;
            primed_d[clear_idx[IDXW-1:0]] = 1'b0;
        end
        out_valid_d = s2_valid_q;
        out_ch_d    = s2_valid_q ? s2_ch_q : out_ch_q;
        y_out_d     = s2_valid_q ? w_y : y_out_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_x_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_ch_q     <= '0;
            s2_x_q      <= '0;
            s2_acc_q    <= '0;
            s2_xprev_q  <= '0;
            s2_primed_q <= 1'b0;
            acc_q       <= '{default: '0};
            xprev_q     <= '{default: '0};
            primed_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            y_out_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ch_q     <= s1_ch_d;
            s1_x_q      <= s1_x_d;
            s2_valid_q  <= s2_valid_d;
            s2_ch_q     <= s2_ch_d;
            s2_x_q      <= s2_x_d;
            s2_acc_q    <= s2_acc_d;
            s2_xprev_q  <= s2_xprev_d;
            s2_primed_q <= s2_primed_d;
            acc_q       <= acc_d;
            xprev_q     <= xprev_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            y_out_q     <= y_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign y_out     = y_out_q;

endmodule

`default_nettype wire

// File: tb/tb_hpf_mc.sv
// ============================================================================
// Module      : tb_hpf_mc
// Description : Directed self-checking bench for hpf_mc against a sample-level
//               reference model (honours HPF_MC_SATURATE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hpf_mc;

    localparam int WIDTH = 10;
    localparam int NCH   = 4;
    localparam int BCHW  = 3;
    localparam int SHIFT = 5;
    localparam int FRAC  = 6;
    localparam int ACC_MAX = (1 << (WIDTH + FRAC + 1)) - 1;
    localparam int ACC_MIN = -(1 << (WIDTH + FRAC + 1));
`ifdef HPF_MC_SATURATE_EN
    localparam int SAT_EXP = 511;
`else
    localparam int SAT_EXP = -24;
`endif

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             in_valid;
    logic [BCHW-1:0]  in_ch;
    logic [WIDTH-1:0] x_in;
    logic             clear_ch;
    logic [BCHW-1:0]  clear_idx;
    logic             out_valid;
    logic [BCHW-1:0]  out_ch;
    logic [WIDTH-1:0] y_out;

    hpf_mc #(
        .WIDTH(WIDTH), .CHANNELS(NCH), .SHIFT(SHIFT), .FRAC(FRAC), .CHW(BCHW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ch(in_ch),
        .x_in(x_in), .clear_ch(clear_ch), .clear_idx(clear_idx),
        .out_valid(out_valid), .out_ch(out_ch), .y_out(y_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int ch; int x; int due; } pend_t;
    typedef struct { int ch; int y; int due; } exp_t;

    pend_t pend[$];
    exp_t  expq[$];
    int    m_acc[NCH];
    int    m_xp[NCH];
    bit    m_pr[NCH];
    int    mlog_ch[$];
    int    mlog_y[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_err = 0;
    int    n_out = 0;
    int    last_y = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic int reduce_y(input int y);
`ifdef HPF_MC_SATURATE_EN
        if (y > (1 << (WIDTH - 1)) - 1) return (1 << (WIDTH - 1)) - 1;
        if (y < -(1 << (WIDTH - 1))) return -(1 << (WIDTH - 1));
        return y;
`else
        int r;
        r = y & ((1 << WIDTH) - 1);
        if (r >= (1 << (WIDTH - 1))) r = r - (1 << WIDTH);
        return r;
`endif
    endfunction

    // Reference: a sample reads/updates its channel at its output edge; a clear at that edge wins.
    task automatic model_edge(input bit v, input int ch, input int x, input bit e,
                              input bit clr, input int cidx, input bit rn);
        int d, a, y;
        pend_t p;
        cyc++;
        if (!rn) begin
            pend.delete();
            expq.delete();
            for (int i = 0; i < NCH; i++) begin
                m_acc[i] = 0; m_xp[i] = 0; m_pr[i] = 0;
            end
            return;
        end
        while (pend.size() > 0 && pend[0].due == cyc) begin
            p = pend.pop_front();
            if (!m_pr[p.ch]) begin
                m_acc[p.ch] = 0;
                m_pr[p.ch]  = 1;
                y = 0;
            end else begin
                d = p.x - m_xp[p.ch];
                a = m_acc[p.ch] + d * (1 << FRAC) - (m_acc[p.ch] >>> SHIFT);
                if (a > ACC_MAX) a = ACC_MAX;
                if (a < ACC_MIN) a = ACC_MIN;
                m_acc[p.ch] = a;
                y = reduce_y(a >>> FRAC);
            end
            m_xp[p.ch] = p.x;
            expq.push_back('{ch: p.ch, y: y, due: cyc});
            mlog_ch.push_back(p.ch);
            mlog_y.push_back(y);
        end
        if (clr && cidx < NCH) begin
            m_acc[cidx] = 0; m_xp[cidx] = 0; m_pr[cidx] = 0;
        end
        if (v && e && ch < NCH) pend.push_back('{ch: ch, x: x, due: cyc + 2});
    endtask

    task automatic step(input bit v, input int ch, input int x, input bit e,
                        input bit clr, input int cidx, input bit rn);
        in_valid  = v;
        in_ch     = BCHW'(ch);
        x_in      = WIDTH'(x);
        en        = e;
        clear_ch  = clr;
        clear_idx = BCHW'(cidx);
        rst_n     = rn;
        @(posedge clk);
        model_edge(v, ch, x, e, clr, cidx, rn);
        @(negedge clk);
    endtask

    task automatic send(input int ch, input int x);
        step(1'b1, ch, x, 1'b1, 1'b0, 0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b1);
    endtask

    task automatic clear_log();
        mlog_ch.delete();
        mlog_y.delete();
    endtask

    task automatic check_log(input string tag, input int ch, input int e[6], input int n);
        int got[$];
        foreach (mlog_ch[i]) if (mlog_ch[i] == ch) got.push_back(mlog_y[i]);
        chk({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) chk(tag, got[i], e[i]);
    endtask

    // Cycle-by-cycle comparison against the model's expected output queue
    initial begin
        exp_t ex;
        int   yv;
        forever begin
            @(posedge clk);
            #1;
            yv = int'($signed(y_out));
            if (!rst_n) begin
                last_y = 0;
            end else if (out_valid) begin
                n_out++;
                if (expq.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    ex = expq.pop_front();
                    chk("out_latency", cyc, ex.due);
                    chk("out_ch", int'(out_ch), ex.ch);
                    chk("y_out", yv, ex.y);
                end
                last_y = yv;
            end else begin
                chk("y_out_hold", yv, last_y);
                if (expq.size() > 0 && expq[0].due <= cyc) begin
                    ex = expq.pop_front();
                    chk("missing_out_valid_ch", -1, ex.ch);
                end
            end
        end
    end

    initial begin
        int n0;
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_ch = '0; x_in = '0;
        clear_ch = 1'b0; clear_idx = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_ch", int'(out_ch), 0);
        chk("reset_y_out", int'(y_out), 0);

        // Priming / DC rejection
        clear_log();
        for (int i = 0; i < 30; i++) send(0, 300);
        idle(3);
        chk("dc_count", mlog_y.size(), 30);
        n0 = 0;
        foreach (mlog_y[i]) if (mlog_y[i] != 0) n0++;
        chk("dc_nonzero", n0, 0);

        // Step decay, widely spaced
        clear_log();
        send(1, 0); idle(2);
        for (int i = 0; i < 3; i++) begin send(1, 100); idle(2); end
        idle(2);
        check_log("step_ch1", 1, '{0, 100, 96, 93, 0, 0}, 4);

        // Accumulator growth beyond WIDTH: saturate or wrap on y
        clear_log();
        send(2, -500); send(2, 500); idle(3);
        check_log("sat_ch2", 2, '{0, SAT_EXP, 0, 0, 0, 0}, 2);

        // Forwarding: back-to-back, then interleaved after a clear
        clear_log();
        send(3, 0); send(3, 100); send(3, 100); send(3, 100); idle(3);
        check_log("fwd_b2b_ch3", 3, '{0, 100, 96, 93, 0, 0}, 4);
        step(1'b0, 0, 0, 1'b1, 1'b1, 3, 1'b1);
        clear_log();
        send(3, 0); send(0, 300); send(3, 100); send(0, 300);
        send(3, 100); send(0, 300); send(3, 100); idle(3);
        check_log("fwd_intl_ch3", 3, '{0, 100, 96, 93, 0, 0}, 4);

        // Clear racing S1/S2, and an out-of-range clear index
        clear_log();
        step(1'b1, 1, 50, 1'b1, 1'b1, 1, 1'b1);
        send(1, 50); idle(2);
        send(1, 80); idle(2);
        send(1, 90); idle(1);
        step(1'b0, 0, 0, 1'b1, 1'b1, 1, 1'b1);
        idle(2);
        send(1, 90); idle(2);
        step(1'b1, 1, 100, 1'b1, 1'b1, 5, 1'b1);
        idle(3);
        check_log("clear_ch1", 1, '{0, 0, 30, 39, 0, 10}, 6);

        // Invalid tag and en=0 produce nothing and leave state alone
        clear_log();
        n0 = n_out;
        send(5, 100);
        step(1'b1, 0, 999, 1'b0, 1'b0, 0, 1'b1);
        idle(3);
        chk("drop_no_out", n_out - n0, 0);
        send(0, 300); idle(3);
        check_log("en_hold_ch0", 0, '{0, 0, 0, 0, 0, 0}, 1);

        // Reset with samples in flight, then re-prime
        clear_log();
        n0 = n_out;
        send(2, 100); send(2, 200);
        step(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
        chk("midrst_y_out", int'(y_out), 0);
        idle(3);
        chk("midrst_no_out", n_out - n0, 0);
        send(0, 300); send(3, 40); idle(3);
        check_log("reprime_ch0", 0, '{0, 0, 0, 0, 0, 0}, 1);
        check_log("reprime_ch3", 3, '{0, 0, 0, 0, 0, 0}, 1);

        idle(4);
        chk("expq_drained", expq.size(), 0);
        chk("pend_drained", pend.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hpf_mc.md
# hpf_mc

Multi-channel, time-multiplexed first-order DC-blocking high-pass filter for the BPM pre-processing chain. It replaces the single-channel HPF and generalises it in sample width, channel count and cutoff shift. It adds per-channel first-sample priming, per-channel clear, and a two-stage pipeline with same-channel forwarding. It sits between the ADC sample mux and the downstream LPF/peak detector, carrying a channel tag alongside each sample.

## Interface
- WIDTH, 10: signed sample width of x_in and y_out.
- CHANNELS, 4: number of independent filter channels, ≥1.
- SHIFT, 5: pole coefficient exponent, alpha = 1 - 2^-SHIFT, range 1..12.
- FRAC, 6: fractional bits held in the per-channel output accumulator.
- CHW, $clog2(CHANNELS) (min 1): channel tag width.

- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  reset; synchronous and active-low.
- en  in  1  global enable; a sample is accepted only when en=1.
- in_valid  in  1  x_in/in_ch are valid this cycle.
- in_ch  in  CHW  channel tag of the input sample.
- x_in  in  WIDTH  signed input sample.
- clear_ch  in  1  one-cycle pulse; clears state of channel clear_idx.
- clear_idx  in  CHW  channel to clear.
- out_valid  out  1  y_out/out_ch valid this cycle.
- out_ch  out  CHW  channel tag of y_out.
- y_out  out  WIDTH  signed filtered sample.

## Operation
- Per-channel state:
  - x_prev[ch]: WIDTH bits.
  - acc[ch]: signed, WIDTH+FRAC+2 bits.
  - primed[ch]: 1 bit.
- Accept: in_valid & en & (in_ch < CHANNELS). Tags ≥ CHANNELS are dropped silently and produce no output.
- Stage 1 (S1) registers x, ch and the channel's state. It reads bypassed state when S2 holds the same channel.
- Stage 2 (S2) computes the result and writes the state arrays, out_valid, out_ch and y_out.
- Unprimed channel:
  - acc_new = 0, x_prev = x, primed = 1.
  - Output is 0; no start-up step transient.
- Primed channel:
  - d = x - x_prev[ch], WIDTH+1 bits.
  - acc_new = acc + (d << FRAC) - (acc >>> SHIFT).
  - acc_new saturates to its own width.
  - x_prev = x.
- Output:
  - y = acc_new >>> FRAC (arithmetic, floor).
  - y is then reduced to WIDTH bits per Configuration.
- Forwarding: a same-channel sample in S1 uses S2's new state. Back-to-back same-channel samples must give results identical to widely spaced ones.
- clear_ch: at the clock edge, sets acc=0, x_prev=0, primed=0 for clear_idx.
  - Clear wins over a simultaneous S2 write to the same channel. The S2 output still emits, but its state write is dropped.
  - An S1 sample of the cleared channel sees primed=0 through bypass, so it is processed as a first sample.
  - clear_idx ≥ CHANNELS: no effect.
- en=0: no new samples accepted. Samples already in the pipeline drain normally. State is held.

## Timing
- Latency: exactly 2 cycles from the accept edge to out_valid. Throughput is 1 sample/cycle with no backpressure.
- out_valid is a one-cycle pulse per accepted sample. out_ch equals the accepted in_ch.
- Reset values: out_valid=0, out_ch=0, y_out=0; all acc, x_prev, primed = 0; pipeline valids = 0.
- Reset mid-operation: in-flight samples are discarded with no out_valid. The first post-reset sample of each channel re-primes it.
- y_out holds its last value while out_valid=0.

## Configuration
- HPF_MC_SATURATE_EN defined: y saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- HPF_MC_SATURATE_EN undefined: y wraps (two's-complement truncation to WIDTH bits).
- The internal acc always saturates in both builds.

## Test plan
All scenarios use defaults (WIDTH=10, SHIFT=5, FRAC=6).
- Priming/DC: ch0 first sample x=300, then 29 more at 300 → 30 outputs, all y_out=0, out_ch=0, each 2 cycles after its accept.
- Step decay: ch1 primed with 0, then x=100 ×3 → y_out = 100, 96, 93 (acc 6400, 6200, 6007).
- Saturation: ch2 primed with -500, then x=500 → y_out=511 with HPF_MC_SATURATE_EN; y_out=-24 without it.
- Forwarding: run the step sequence on ch3 back-to-back, then interleaved with ch0 traffic → identical ch3 outputs 100, 96, 93.
- Clear/invalid/en:
  - clear_ch on ch1 in the same cycle as a ch1 sample x=50 → that sample outputs 0; the next x=50 outputs 0.
  - in_ch=5 with CHANNELS=4 → no out_valid.
  - en=0 with in_valid=1 → no out_valid, state unchanged.
- Reset mid-stream: assert rst_n=0 for 1 cycle with samples in S1 and S2 → no out_valid for them. A following x=300 on ch0 outputs 0 (re-primed).
